data_memory_responder: RTL
==========================

# data_memory_responder

Data-memory responder at the far end of the MEM-stage data interface. Accepts the MEM stage's address, read and write strobes, write data and write-size code, and holds a word-addressed big-endian memory array. Returns the full aligned word on reads; the MEM stage does all byte and halfword extraction. Performs byte-lane merging on partial stores and, optionally, inserts read wait states with a stall back to the pipeline.

## Interface
- ADDR_WIDTH, default 10: word-address bits. Array depth is 2^ADDR_WIDTH words.
- WAIT_CYCLES, default 2: extra read latency when wait states are compiled in. Legal range 1..15.
- CLK  in  1  sole clock; all state updates on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- data_address_2DM  in  32  byte address. Reads use bits [ADDR_WIDTH+1:2]; writes also use [1:0].
- data_write_2DM  in  32  store data, right-justified for partial sizes.
- data_write_size_2DM  in  2  0 = word, 1 = one byte, 2 = two bytes, 3 = three bytes.
- MemRead_2DM  in  1  read request.
- MemWrite_2DM  in  1  write request.
- data_read_fDM  out  32  aligned read word.
- DMEM_Stall  out  1  pipeline hold request (wait-state builds only; tied 0 otherwise).
- DMEM_Err  out  1  one-cycle registered pulse on an illegal access.

## Operation
- **Byte order:** big-endian. Byte offset 0 = bits [31:24] of the word; offset 3 = bits [7:0].
- **Address range:** upper address bits above ADDR_WIDTH+1 are ignored; the address wraps modulo the array size.
- **Write, size n (n = 4 for code 0), offset o = address[1:0]:** bytes o..o+n-1 of the word are written with the n low bytes of data_write_2DM. The most significant of those bytes goes to the lowest offset.
  - Size code 0 ignores o and writes the whole word.
  - If o+n > 4, bytes beyond offset 3 are dropped (never wrap into the next word) and DMEM_Err pulses.
  - Untouched bytes keep their value.
- **Write commit:** at the rising edge while MemWrite_2DM = 1 and RESET = 0.
- **Read:** returns the whole word at the word address. Offset bits are ignored.
- **Read and write both high:** the write executes, the read is ignored, data_read_fDM returns 0 for that cycle, and DMEM_Err pulses.
- **Array contents:** not reset.
- **Illegal-parameter error:** WAIT_CYCLES = 0 in a wait-state build is a fatal elaboration error.

## Timing
- **Without the wait-state feature:**
  - data_read_fDM is combinational from the array.
  - A same-cycle write is not forwarded; the read sees the old value and the new value appears after the edge.
  - DMEM_Stall is constantly 0.
- **With the wait-state feature:** FSM with states IDLE, WAIT, DONE.
  - IDLE: if MemRead_2DM = 1 and MemWrite_2DM = 0, DMEM_Stall = 1 combinationally. Next edge moves to WAIT with cnt = WAIT_CYCLES-1.
  - WAIT: DMEM_Stall = 1. If cnt = 0, register the array word into data_read_fDM and move to DONE; else decrement cnt.
  - DONE: DMEM_Stall = 0 and data_read_fDM is valid. The pipeline advances on this edge, then the FSM returns to IDLE.
  - Read latency is WAIT_CYCLES+2 cycles from request to pipeline advance, with WAIT_CYCLES+1 stalled cycles.
  - Inputs must be held stable while DMEM_Stall = 1.
  - Writes never stall. A write in IDLE commits at the edge.
  - Back-to-back reads each take the full latency.
  - data_read_fDM holds its last value outside DONE.
- **Reset values:** data_read_fDM = 0, DMEM_Stall = 0, DMEM_Err = 0, FSM = IDLE, cnt = 0.
- **Reset mid-read:** the pending read is dropped and the FSM returns to IDLE. No write commits while RESET = 1.
- **DMEM_Err:** registered; asserts the cycle after the offending access, for exactly one cycle.

## Configuration
- **DMEM_WAIT_STATES_EN defined:** the FSM, counter and registered read path are built. DMEM_Stall is live and WAIT_CYCLES is honoured.
- **DMEM_WAIT_STATES_EN undefined:** zero-wait asynchronous read; no FSM; DMEM_Stall = 0. WAIT_CYCLES is unused.

## Structure
- **Shared package dmem_pkg:**
  - size-code constants SZ_WORD = 0, SZ_BYTE = 1, SZ_HALF = 2, SZ_TRI = 3;
  - FSM state typedef dmem_state_t {IDLE, WAIT, DONE};
  - byte-offset helper constants.
- **Sub-module dmem_lane_mask:** combinational. Inputs are size code, offset and data; outputs are a 4-bit byte-enable, 32-bit lane-aligned write data, and an overflow flag. Instantiated once.

## Test plan
- **Word write/read:** write 0xDEADBEEF at 0x100 with size 0, then read 0x102.
  - Required: data_read_fDM = 0xDEADBEEF.
- **Byte write:** word 0x11223344 at 0x200; write size 1, data 0x000000AA, at 0x201.
  - Required: read returns 0x11AA3344.
- **Three-byte write, both offsets:** word 0x11223344 at 0x300.
  - Size 3, data 0x00AABBCC at 0x301: read returns 0x11AABBCC.
  - Repeat at 0x302: word becomes 0x1122AABB, and DMEM_Err pulses once.
- **Wait-state read:** build with DMEM_WAIT_STATES_EN and WAIT_CYCLES = 2; read 0x100 holding 0xDEADBEEF.
  - Required: DMEM_Stall high for exactly 3 cycles, then data_read_fDM = 0xDEADBEEF for 1 cycle with stall low.
- **Reset mid-read:** assert RESET during WAIT.
  - Required: stall drops immediately, data_read_fDM = 0, FSM = IDLE, memory unchanged.
- **Simultaneous read and write:** MemRead_2DM = MemWrite_2DM = 1 at 0x400, data 0x12345678.
  - Required: word written, data_read_fDM = 0, DMEM_Err pulses next cycle, no stall.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared size codes, FSM state type and byte-lane constants for the data memory responder
package dmem_pkg;

  localparam logic [1:0] SZ_WORD = 2'd0;
  localparam logic [1:0] SZ_BYTE = 2'd1;
  localparam logic [1:0] SZ_HALF = 2'd2;
  localparam logic [1:0] SZ_TRI  = 2'd3;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_BITS      = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/dmem_lane_mask.sv
// rtl/dmem_lane_mask.sv - big-endian byte-enable and lane alignment for partial stores
import dmem_pkg::*;

module dmem_lane_mask (
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_data,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_overflow
);

  logic [2:0]  w_n;
  logic [2:0]  w_off;
  logic [2:0]  w_rel;
  logic [2:0]  w_idx;
  logic [31:0] w_shift;

  // o_be[k] enables big-endian byte offset k; the highest stored byte lands on the lowest offset
  always_comb begin
    o_be    = '0;
    o_wdata = '0;
    w_rel   = '0;
    w_idx   = '0;
    w_shift = '0;
    w_n     = 3'd4;
    case (i_size)
      SZ_BYTE: w_n = 3'd1;
      SZ_HALF: w_n = 3'd2;
      SZ_TRI:  w_n = 3'd3;
      default: w_n = 3'd4;
    endcase
    w_off = (i_size == SZ_WORD) ? 3'd0 : {1'b0, i_offset};
    for (int k = 0; k < BYTES_PER_WORD; k++) begin
      w_rel = 3'(k) - w_off;
      if ((3'(k) >= w_off) && (w_rel < w_n)) begin
        w_idx   = w_n - 3'd1 - w_rel;
        w_shift = i_data >> {w_idx, 3'b000};
        o_be[k] = 1'b1;
        o_wdata[BYTE_BITS*(BYTES_PER_WORD-1-k) +: BYTE_BITS] = w_shift[7:0];
      end
    end
    o_overflow = (w_off + w_n) > 3'd4;
  end

endmodule

// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - word-addressed big-endian data memory with byte-lane stores
// Optional read wait states with pipeline stall when DMEM_WAIT_STATES_EN is defined.
import dmem_pkg::*;

module data_memory_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] data_address_2DM,
  input  logic [31:0] data_write_2DM,
  input  logic [1:0]  data_write_size_2DM,
  input  logic        MemRead_2DM,
  input  logic        MemWrite_2DM,
  output logic [31:0] data_read_fDM,
  output logic        DMEM_Stall,
  output logic        DMEM_Err
);

  logic [31:0]           r_mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [31:0]           w_word;
  logic [3:0]            w_be;
  logic [31:0]           w_lane_data;
  logic                  w_ovf;
  logic                  w_rw_both;
  logic                  r_err;

  assign w_waddr   = data_address_2DM[ADDR_WIDTH+1:2];
  assign w_word    = r_mem[w_waddr];
  assign w_rw_both = MemRead_2DM & MemWrite_2DM;

  dmem_lane_mask u_lane_mask (
    .i_size     (data_write_size_2DM),
    .i_offset   (data_address_2DM[1:0]),
    .i_data     (data_write_2DM),
    .o_be       (w_be),
    .o_wdata    (w_lane_data),
    .o_overflow (w_ovf)
  );

  // Array is deliberately not reset; RESET only blocks the commit
  always_ff @(posedge CLK) begin
    if (!RESET && MemWrite_2DM) begin
      for (int k = 0; k < BYTES_PER_WORD; k++) begin
        if (w_be[k]) begin
          r_mem[w_waddr][BYTE_BITS*(BYTES_PER_WORD-1-k) +: BYTE_BITS] <=
            w_lane_data[BYTE_BITS*(BYTES_PER_WORD-1-k) +: BYTE_BITS];
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_err <= 1'b0;
    end else begin
      r_err <= MemWrite_2DM & (MemRead_2DM | w_ovf);
    end
  end

  assign DMEM_Err = r_err;

`ifdef DMEM_WAIT_STATES_EN
  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
    $fatal(1, "data_memory_responder: WAIT_CYCLES must be 1..15");
  end

  dmem_state_t r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_rdata;
  logic        w_unused;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (MemRead_2DM && !MemWrite_2DM) begin
            r_state <= WAIT;
            r_cnt   <= 4'(WAIT_CYCLES - 1);
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) begin
            r_rdata <= w_word;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign DMEM_Stall    = !RESET && (((r_state == IDLE) && MemRead_2DM && !MemWrite_2DM) ||
                                    (r_state == WAIT));
  assign data_read_fDM = w_rw_both ? 32'd0 : r_rdata;
  assign w_unused      = ^{data_address_2DM[31:ADDR_WIDTH+2]};
`else
  logic w_unused;

  assign DMEM_Stall    = 1'b0;
  assign data_read_fDM = (RESET || w_rw_both) ? 32'd0 : w_word;
  assign w_unused      = ^{data_address_2DM[31:ADDR_WIDTH+2], 32'(WAIT_CYCLES)};
`endif

endmodule
